// File: rtl/conv_window_seq_pkg.sv
// Shared definitions for the convolution window sequencer and the PE control stage:
// tap offsets, sequencer FSM states and tap-lane slicing helpers.
package conv_window_seq_pkg;

  localparam int NTAPS = 9;

  // Tap k sits at (DY[k], DX[k]) relative to the window centre.
  localparam int DY [NTAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int DX [NTAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Tap 0 occupies the most significant lane of every packed tap bus.
  function automatic int lane_lo(input int k, input int lane_w);
    return lane_w * (NTAPS - 1 - k);
  endfunction

  function automatic int mask_bit(input int k);
    return NTAPS - 1 - k;
  endfunction

endpackage

// File: rtl/conv_tap_gen.sv
// Combinational 3x3 pad-1 tap generator: centre (r, c) -> nine clipped
// row/column indices plus the per-tap valid mask.
module conv_tap_gen
  import conv_window_seq_pkg::*;
#(
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic [height_b-1:0]       r,
  input  logic [width_b-1:0]        c,
  input  logic [width_b-1:0]        img_w,
  input  logic [height_b-1:0]       img_h,
  output logic [width_b*NTAPS-1:0]  wr,
  output logic [height_b*NTAPS-1:0] hr,
  output logic [NTAPS-1:0]          mask
);

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic signed [height_b:0] rs;
    logic signed [width_b:0]  cs;
    logic                     ok;

    // One guard bit keeps r-1 at r=0 negative instead of wrapping.
    assign rs = $signed({1'b0, r}) + $signed((height_b + 1)'(DY[k]));
    assign cs = $signed({1'b0, c}) + $signed((width_b + 1)'(DX[k]));
    assign ok = !rs[height_b] && (rs < $signed({1'b0, img_h})) &&
                !cs[width_b]  && (cs < $signed({1'b0, img_w}));

    assign mask[mask_bit(k)]                   = ok;
    assign wr[lane_lo(k, width_b) +: width_b]  = ok ? cs[width_b-1:0] : '0;
    assign hr[lane_lo(k, height_b) +: height_b] = ok ? rs[height_b-1:0] : '0;
  end

endmodule

// File: rtl/conv_window_seq.sv
// Read-side window sequencer: one 3x3 window per (row, col, channel group).
// Optional CONV_WINDOW_SEQ_STRIDE2_EN adds a stride2 input (row/col step of 2).
module conv_window_seq
  import conv_window_seq_pkg::*;
#(
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [width_b-1:0]         img_w,
  input  logic [height_b-1:0]        img_h,
  input  logic [2:0]                 n_groups,
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
  input  logic                       stride2,
`endif
  input  logic                       stall,
  output logic [width_b*NTAPS-1:0]   readi_wr,
  output logic [height_b*NTAPS-1:0]  readi_hr,
  output logic [NTAPS-1:0]           en_read,
  output logic                       en_bias,
  output logic [2:0]                 stepr,
  output logic                       en_pe,
  output logic                       busy,
  output logic                       done
);

  state_t               state;
  logic [height_b-1:0]  r_q, h_q, sel_r, sel_h;
  logic [width_b-1:0]   c_q, w_q, sel_c, sel_w;
  logic [2:0]           g_q, ng_q, sel_g, sel_ng;
  logic [width_b:0]     c_sum;
  logic [height_b:0]    r_sum;
  logic                 idle, start_ok, emit, step_s;
  logic                 g_last, c_wrap, r_wrap, last;
  logic [width_b*NTAPS-1:0]  tap_wr;
  logic [height_b*NTAPS-1:0] tap_hr;
  logic [NTAPS-1:0]          tap_mask;

  assign idle     = (state == ST_IDLE);
  assign start_ok = idle && start && (img_w != '0) && (img_h != '0);
  assign emit     = start_ok || ((state == ST_RUN) && !stall);

  // The start cycle already emits window (0,0,0) from the live size inputs,
  // so the first window is visible right after the start edge.
  assign sel_r  = idle ? '0 : r_q;
  assign sel_c  = idle ? '0 : c_q;
  assign sel_g  = idle ? '0 : g_q;
  assign sel_w  = idle ? img_w : w_q;
  assign sel_h  = idle ? img_h : h_q;
  assign sel_ng = idle ? n_groups : ng_q;

`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
  logic s2_q;
  assign step_s = idle ? stride2 : s2_q;
`else
  assign step_s = 1'b0;
`endif

  assign c_sum  = {1'b0, sel_c} + {{(width_b-1){1'b0}}, step_s, ~step_s};
  assign r_sum  = {1'b0, sel_r} + {{(height_b-1){1'b0}}, step_s, ~step_s};
  assign g_last = (sel_g == sel_ng);
  assign c_wrap = (c_sum >= {1'b0, sel_w});
  assign r_wrap = (r_sum >= {1'b0, sel_h});
  assign last   = g_last && c_wrap && r_wrap;

  conv_tap_gen #(
    .width_b  (width_b),
    .height_b (height_b)
  ) u_tap_gen (
    .r     (sel_r),
    .c     (sel_c),
    .img_w (sel_w),
    .img_h (sel_h),
    .wr    (tap_wr),
    .hr    (tap_hr),
    .mask  (tap_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      g_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      ng_q     <= '0;
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
      s2_q     <= 1'b0;
`endif
      readi_wr <= '0;
      readi_hr <= '0;
      en_read  <= '0;
      en_bias  <= 1'b0;
      stepr    <= '0;
      en_pe    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (start_ok) begin
        w_q  <= img_w;
        h_q  <= img_h;
        ng_q <= n_groups;
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
        s2_q <= stride2;
`endif
      end
      if (emit) begin
        readi_wr <= tap_wr;
        readi_hr <= tap_hr;
        en_read  <= tap_mask;
        stepr    <= sel_g;
        en_bias  <= (sel_g == 3'd0);
        en_pe    <= 1'b1;
        busy     <= 1'b1;
        // Group is innermost, then column, then row.
        if (g_last) begin
          g_q <= '0;
          if (c_wrap) begin
            c_q <= '0;
            r_q <= r_wrap ? '0 : r_sum[height_b-1:0];
          end else begin
            c_q <= c_sum[width_b-1:0];
          end
        end else begin
          g_q <= sel_g + 3'd1;
        end
        state <= last ? ST_DONE : ST_RUN;
      end
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !start_ok) state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          en_pe <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_seq.sv
// Scoreboard bench for conv_window_seq: expected windows are queued at start
// and compared against every en_pe cycle.
module tb_conv_window_seq;

  localparam int WB = 7;
  localparam int HB = 3;

  typedef struct packed {
    logic [8:0]      er;
    logic [WB*9-1:0] wr;
    logic [HB*9-1:0] hr;
    logic [2:0]      g;
  } win_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [WB-1:0]   img_w = '0;
  logic [HB-1:0]   img_h = '0;
  logic [2:0]      n_groups = '0;
  logic            stall = 1'b0;
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
  logic            stride2 = 1'b0;
`endif
  logic [WB*9-1:0] readi_wr;
  logic [HB*9-1:0] readi_hr;
  logic [8:0]      en_read;
  logic            en_bias;
  logic [2:0]      stepr;
  logic            en_pe;
  logic            busy;
  logic            done;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   win_cnt, done_cnt, done_cyc, rel_cyc, bias_cnt;
  bit   active = 1'b0;
  logic [8:0]  first_er, last_er;
  logic [WB-1:0] first_c4, last_c4;
  logic [HB-1:0] first_r4, last_r4;

  conv_window_seq #(
    .width_b  (WB),
    .height_b (HB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .img_w    (img_w),
    .img_h    (img_h),
    .n_groups (n_groups),
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
    .stride2  (stride2),
`endif
    .stall    (stall),
    .readi_wr (readi_wr),
    .readi_hr (readi_hr),
    .en_read  (en_read),
    .en_bias  (en_bias),
    .stepr    (stepr),
    .en_pe    (en_pe),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic win_t model_win(input int r, input int c, input int w, input int h, input int g);
    win_t m;
    int rr, cc;
    m = '0;
    m.g = g[2:0];
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
        m.er[8-k] = 1'b1;
        m.wr[WB*(8-k) +: WB] = cc[WB-1:0];
        m.hr[HB*(8-k) +: HB] = rr[HB-1:0];
      end
    end
    return m;
  endfunction

  // Held windows (stall high for the coming edge) are compared but not popped.
  always @(negedge clk) begin
    if (active) begin
      rel_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = rel_cyc;
      end
      if (en_pe) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_window", 1, 0);
        end else begin
          check_eq("en_read", en_read, exp_q[0].er);
          check_eq("readi_wr", readi_wr, exp_q[0].wr);
          check_eq("readi_hr", readi_hr, exp_q[0].hr);
          check_eq("stepr", stepr, exp_q[0].g);
          check_eq("en_bias", en_bias, exp_q[0].g == 3'd0);
          check_eq("busy_in_run", busy, 1);
          if (!stall) begin
            if (win_cnt == 0) begin
              first_er = en_read;
              first_c4 = readi_wr[WB*4 +: WB];
              first_r4 = readi_hr[HB*4 +: HB];
            end
            last_er = en_read;
            last_c4 = readi_wr[WB*4 +: WB];
            last_r4 = readi_hr[HB*4 +: HB];
            if (en_bias) bias_cnt++;
            win_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_layer(input int w, input int h, input int ng, input bit s2, output int n);
    int step;
    step = s2 ? 2 : 1;
    n = 0;
    for (int r = 0; r < h; r += step)
      for (int c = 0; c < w; c += step)
        for (int g = 0; g <= ng; g++) begin
          exp_q.push_back(model_win(r, c, w, h, g));
          n++;
        end
  endtask

  task automatic run_layer(input int w, input int h, input int ng, input int stall_at,
                           input int stall_len, input bit restart, input bit s2);
    int n;
    int held;
    push_layer(w, h, ng, s2, n);
    held = (stall_at >= 0) ? stall_len : 0;
    win_cnt = 0; done_cnt = 0; done_cyc = -1; rel_cyc = -1; bias_cnt = 0;
    img_w = w[WB-1:0];
    img_h = h[HB-1:0];
    n_groups = ng[2:0];
`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
    stride2 = s2;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    active = 1'b1;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      stall = (stall_at >= 0 && i >= stall_at && i < stall_at + stall_len);
      start = restart && (i == 2);
      if (restart && i == 2) img_w = WB'(w + 1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    active = 1'b0;
    check_eq("window_count", win_cnt, n);
    check_eq("done_pulses", done_cnt, 1);
    if (n > 0) check_eq("done_cycle", done_cyc, n + held);
    else check_eq("zero_size_done_early", (done_cyc >= 0 && done_cyc <= 2), 1);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_en_pe", en_pe, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {readi_wr, readi_hr, en_read, en_bias, stepr, en_pe, busy, done}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 4x3 single group: corner masks at both ends.
    run_layer(4, 3, 0, -1, 0, 1'b0, 1'b0);
    check_eq("first_en_read", first_er, 9'b000011011);
    check_eq("first_tap4", {first_r4, first_c4}, {3'd0, 7'd0});
    check_eq("last_en_read", last_er, 9'b110110000);
    check_eq("last_tap4", {last_r4, last_c4}, {3'd2, 7'd3});

    // 3x3 with three groups.
    run_layer(3, 3, 2, -1, 0, 1'b0, 1'b0);
    check_eq("bias_count", bias_cnt, 9);

    // Stall held over window 5.
    run_layer(4, 3, 0, 4, 3, 1'b0, 1'b0);

    // Zero-sized layers and a single pixel.
    run_layer(4, 0, 0, -1, 0, 1'b0, 1'b0);
    run_layer(0, 3, 0, -1, 0, 1'b0, 1'b0);
    run_layer(1, 1, 1, -1, 0, 1'b0, 1'b0);

    // Reset asserted mid-layer.
    push_layer(4, 3, 0, 1'b0, n);
    win_cnt = 0; done_cnt = 0; rel_cyc = -1;
    img_w = 7'd4; img_h = 3'd3; n_groups = 3'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    active = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    active = 1'b0;
    check_eq("busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("async_reset_outputs", {readi_wr, readi_hr, en_read, en_bias, stepr, en_pe, busy, done}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_eq("post_reset_idle", {en_pe, busy, done}, 0);
    run_layer(4, 3, 0, -1, 0, 1'b0, 1'b0);

    // Start pulsed again while running, with a changed width.
    run_layer(4, 3, 0, -1, 0, 1'b1, 1'b0);

`ifdef CONV_WINDOW_SEQ_STRIDE2_EN
    run_layer(4, 4, 0, -1, 0, 1'b0, 1'b1);
    run_layer(5, 3, 1, -1, 0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
